// File: rtl/stream_demux_1to2.sv
// ---------------------------------------------------------------------------
// stream_demux_1to2
//   Registered 1-to-2 stream demultiplexer. Each input word is steered by
//   in_sel to output X (0) or Y (1). Every branch owns a 2-entry FIFO, so a
//   stalled consumer on one side never blocks, corrupts or reorders the other.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid/ready/data    input stream; in_sel picks the destination branch
//   x_valid/ready/data     X branch output stream (buffer head)
//   y_valid/ready/data     Y branch output stream (buffer head)
//   x_level, y_level       per-branch occupancy, 0..2
// ---------------------------------------------------------------------------

// Per-branch 2-entry FIFO with 1-bit wrapping read/write pointers.
// Input: i_push (already qualified by the parent), i_data, i_ready (consumer).
// Output: o_valid, o_data (oldest entry), o_level.
module stream_demux_buf #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [N-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [N-1:0] o_data,
    output logic [1:0]   o_level
);
    logic [1:0][N-1:0] r_mem;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_level;
    logic              w_pop;

    assign o_valid = (r_level != 2'd0);
    // Consumer ready is ignored while empty.
    assign w_pop   = o_valid & i_ready;
    assign o_data  = r_mem[r_rptr];
    assign o_level = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_level <= 2'd0;
        end else begin
            // The parent never pushes into a full buffer, so the write slot
            // is always free even when a pop happens in the same cycle.
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_level <= r_level + 2'd1;
                2'b01:   r_level <= r_level - 2'd1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

module stream_demux_1to2 #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sel,
    output logic         x_valid,
    input  logic         x_ready,
    output logic [N-1:0] x_data,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [N-1:0] y_data,
    output logic [1:0]   x_level,
    output logic [1:0]   y_level
);
    logic [1:0]        w_push;
    logic [1:0]        w_valid;
    logic [1:0]        w_ready;
    logic [1:0][N-1:0] w_data;
    logic [1:0][1:0]   w_level;

    // Ready looks only at the selected branch's occupancy; a same-cycle pop
    // on a full branch does not open it, which keeps ready free of any
    // combinational path from the consumer readies.
    assign in_ready  = (w_level[in_sel] != 2'd2);
    assign w_push[0] = in_valid & in_ready & ~in_sel;
    assign w_push[1] = in_valid & in_ready &  in_sel;
    assign w_ready   = {y_ready, x_ready};

    for (genvar g = 0; g < 2; g++) begin : g_br
        stream_demux_buf #(.N(N)) u_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g]),
            .i_data  (in_data),
            .i_ready (w_ready[g]),
            .o_valid (w_valid[g]),
            .o_data  (w_data[g]),
            .o_level (w_level[g])
        );
    end

    assign x_valid = w_valid[0];
    assign y_valid = w_valid[1];
    assign x_data  = w_data[0];
    assign y_data  = w_data[1];
    assign x_level = w_level[0];
    assign y_level = w_level[1];
endmodule

// File: tb/tb_stream_demux_1to2.sv
module tb_stream_demux_1to2;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_data;
    logic        y_valid;
    logic        y_ready;
    logic [31:0] y_data;
    logic [1:0]  x_level;
    logic [1:0]  y_level;

    int n_chk  = 0;
    int n_fail = 0;

    stream_demux_1to2 #(.N(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_data   (x_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data),
        .x_level  (x_level),
        .y_level  (y_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One vector: inputs held for one cycle; in_ready checked before the
    // edge, outputs and levels checked just after it.
    typedef struct {
        logic        iv;
        logic        sel;
        logic [31:0] d;
        logic        xr;
        logic        yr;
        logic        ir;
        logic        xv;
        logic [31:0] xd;
        logic        yv;
        logic [31:0] yd;
        logic [1:0]  xl;
        logic [1:0]  yl;
    } vec_t;

    function automatic vec_t mk(logic iv, logic sel, logic [31:0] d, logic xr, logic yr,
                                logic ir, logic [1:0] xl, logic [31:0] xd,
                                logic [1:0] yl, logic [31:0] yd);
        vec_t v;
        v.iv = iv; v.sel = sel; v.d = d; v.xr = xr; v.yr = yr; v.ir = ir;
        v.xl = xl; v.xv = (xl != 2'd0); v.xd = xd;
        v.yl = yl; v.yv = (yl != 2'd0); v.yd = yd;
        return v;
    endfunction

    vec_t tv[13];

    // Reference model: one queue per branch.
    logic [31:0] qx[$];
    logic [31:0] qy[$];

    task automatic chk_model();
        chk("rnd_x_valid", 32'(x_valid), 32'(qx.size() != 0));
        chk("rnd_y_valid", 32'(y_valid), 32'(qy.size() != 0));
        chk("rnd_x_level", 32'(x_level), 32'(qx.size()));
        chk("rnd_y_level", 32'(y_level), 32'(qy.size()));
        if (qx.size() != 0) chk("rnd_x_data", x_data, qx[0]);
        if (qy.size() != 0) chk("rnd_y_data", y_data, qy[0]);
    endtask

    initial begin
        logic hold;
        logic exp_ir;
        logic pop_x, pop_y;

        //              iv  sel d             xr  yr  ir  xl  xd            yl  yd
        tv[0]  = mk(1, 0, 32'hDEADBEEF, 1, 1, 1, 1, 32'hDEADBEEF, 0, 32'h0);
        tv[1]  = mk(1, 1, 32'h12345678, 1, 1, 1, 0, 32'h0,        1, 32'h12345678);
        tv[2]  = mk(0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0);
        tv[3]  = mk(1, 0, 32'h1,        0, 1, 1, 1, 32'h1,        0, 32'h0);
        tv[4]  = mk(1, 0, 32'h2,        0, 1, 1, 2, 32'h1,        0, 32'h0);
        tv[5]  = mk(1, 0, 32'h3,        0, 1, 0, 2, 32'h1,        0, 32'h0);
        tv[6]  = mk(1, 1, 32'hA,        0, 0, 1, 2, 32'h1,        1, 32'hA);
        tv[7]  = mk(1, 0, 32'h3,        1, 1, 0, 1, 32'h2,        0, 32'h0);
        tv[8]  = mk(1, 0, 32'h3,        1, 1, 1, 1, 32'h3,        0, 32'h0);
        tv[9]  = mk(0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0);
        tv[10] = mk(1, 0, 32'h5,        0, 1, 1, 1, 32'h5,        0, 32'h0);
        tv[11] = mk(1, 0, 32'h6,        1, 1, 1, 1, 32'h6,        0, 32'h0);
        tv[12] = mk(0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0);

        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        x_ready = 1'b0; y_ready = 1'b0;
        #3;
        chk("rst_x_valid", 32'(x_valid), 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_x_level", 32'(x_level), 32'd0);
        chk("rst_y_level", 32'(y_level), 32'd0);
        chk("rst_x_data",  x_data, 32'd0);
        chk("rst_y_data",  y_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            in_valid = tv[i].iv; in_sel = tv[i].sel; in_data = tv[i].d;
            x_ready = tv[i].xr; y_ready = tv[i].yr;
            #1;
            chk($sformatf("tv%0d_in_ready", i), 32'(in_ready), 32'(tv[i].ir));
            @(posedge clk); #1;
            chk($sformatf("tv%0d_x_valid", i), 32'(x_valid), 32'(tv[i].xv));
            chk($sformatf("tv%0d_y_valid", i), 32'(y_valid), 32'(tv[i].yv));
            chk($sformatf("tv%0d_x_level", i), 32'(x_level), 32'(tv[i].xl));
            chk($sformatf("tv%0d_y_level", i), 32'(y_level), 32'(tv[i].yl));
            if (tv[i].xv) chk($sformatf("tv%0d_x_data", i), x_data, tv[i].xd);
            if (tv[i].yv) chk($sformatf("tv%0d_y_data", i), y_data, tv[i].yd);
        end

        // Random stress against the queue model (both queues empty here).
        in_valid = 1'b0; hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = $urandom_range(0, 1);
                in_data  = $urandom;
            end
            x_ready = ($urandom_range(0, 1) == 1);
            y_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ir = in_sel ? (qy.size() != 2) : (qx.size() != 2);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
            pop_x = (qx.size() != 0) && x_ready;
            pop_y = (qy.size() != 0) && y_ready;
            hold  = in_valid && !exp_ir;
            @(posedge clk);
            if (pop_x) void'(qx.pop_front());
            if (pop_y) void'(qy.pop_front());
            if (in_valid && exp_ir) begin
                if (in_sel) qy.push_back(in_data);
                else        qx.push_back(in_data);
            end
            #1;
            chk_model();
        end

        // Reset mid-operation: fill both branches, then drop rst_n between edges.
        in_valid = 1'b0;
        x_ready = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        x_ready = 1'b0; y_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = k[1]; in_data = 32'h11 * (k + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("full_x_level", 32'(x_level), 32'd2);
        chk("full_y_level", 32'(y_level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_x_valid", 32'(x_valid), 32'd0);
        chk("amid_y_valid", 32'(y_valid), 32'd0);
        chk("amid_x_level", 32'(x_level), 32'd0);
        chk("amid_y_level", 32'(y_level), 32'd0);
        chk("amid_x_data",  x_data, 32'd0);
        chk("amid_y_data",  y_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_y_valid", 32'(y_valid), 32'd1);
        chk("post_rst_y_data",  y_data, 32'h77);
        chk("post_rst_y_level", 32'(y_level), 32'd1);
        chk("post_rst_x_level", 32'(x_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It is the inverse of the 2-to-1 result mux. One N-bit input stream is steered per word, by a select bit, to output X (sel=0) or output Y (sel=1). Each output has a 2-entry buffer, so a stalled destination never corrupts or reorders the other path. It sits between the ALU result stage and two consumers, for example the register writeback and the flag/forwarding unit.

Parameters:
N, 32, width of the data buses in bits.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input word present.
in_ready  output  1  block accepts the input word this cycle.
in_data  input  N  input word.
in_sel  input  1  destination: 0 selects X, 1 selects Y. Sampled with in_data.
x_valid  output  1  X buffer head valid.
x_ready  input  1  X consumer accepts the head.
x_data  output  N  X buffer head word.
y_valid  output  1  Y buffer head valid.
y_ready  input  1  Y consumer accepts the head.
y_data  output  N  Y buffer head word.
x_level  output  2  X buffer occupancy, 0..2.
y_level  output  2  Y buffer occupancy, 0..2.

Behaviour:
- Reset (rst_n low, asynchronous): both buffers empty. x_valid=y_valid=0, x_level=y_level=0, x_data=y_data=0. All stored entries are discarded immediately, including mid-transfer. The first push is possible on the first clock edge after rst_n rises.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. When valid=1 and ready=0, the producer holds valid, data and sel stable.
- in_ready is combinational: in_ready = (in_sel ? y_level : x_level) != 2. It depends only on the selected branch's level, never on x_ready or y_ready. There is no combinational ready path.
- Push: on an input transfer, in_data is written to the buffer of the branch selected by in_sel. The unselected branch is unaffected.
- Latency: a word pushed at edge k appears on {x,y}_data with {x,y}_valid=1 after edge k, when its buffer was empty. Minimum latency is 1 cycle. There is no same-cycle pass-through.
- Output side: {x,y}_valid = level != 0, and {x,y}_data is the oldest entry. A pop occurs on an output transfer.
- Ordering: FIFO order within each branch. No ordering guarantee across branches.
- Per-branch level update per edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, with the new word queued behind the remaining entry
  - neither: unchanged
- Full (level=2): in_ready=0 for words selected to that branch, even when that branch pops in the same cycle. Words selected to the other branch are accepted normally.
- Empty (level=0): valid=0, and the consumer's ready is ignored. Data holds its last value and is not relied upon.
- Both outputs may pop in the same cycle, independently. One push and up to two pops may occur in one cycle.
- Storage: 2 entries per branch, implemented as ping-pong registers or a 2-entry FIFO with 1-bit read/write pointers that wrap modulo 2.
- The block generates no combinational loops.

Test Plan:
- Basic steer: push 0xDEADBEEF with sel=0, then 0x12345678 with sel=1, both outputs ready -> x_data=0xDEADBEEF valid 1 cycle after its push, y_data=0x12345678 valid 1 cycle after its push. Levels return to 0.
- X backpressure: x_ready=0, push 0x1, 0x2, 0x3 with sel=0 -> x_level=2 and in_ready=0 on the third word. Then push 0xA with sel=1 -> accepted and y_data=0xA. Raise x_ready -> X delivers 0x1 then 0x2, and 0x3 is accepted once x_level<2.
- Full with same-cycle pop: x_level=2, x_ready=1, sel=0 word offered -> not accepted that cycle, level drops to 1, and the word is accepted the next cycle.
- Simultaneous push/pop at level 1: X holds 0x5, push 0x6 to X while x_ready=1 -> 0x5 is popped, x_level stays 1, and x_data=0x6 next cycle.
- Random stress: 10,000 random valid/sel/ready cycles -> per-branch scoreboard order matches, no loss or duplication, and a level>2 assertion never fires.
- Reset mid-operation: both buffers full, pull rst_n low asynchronously between edges -> valids, levels and data are 0 immediately. After release, a push of 0x77 with sel=1 yields y_data=0x77 one cycle later.
